// File: rtl/sound_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sound_pkg : APU register addresses, frame-sequencer decode constants and
//             trigger-register decode shared by the sound control sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
package sound_pkg;

  localparam logic [7:0] NR11 = 8'h11;
  localparam logic [7:0] NR14 = 8'h14;
  localparam logic [7:0] NR21 = 8'h16;
  localparam logic [7:0] NR24 = 8'h19;
  localparam logic [7:0] NR31 = 8'h1B;
  localparam logic [7:0] NR34 = 8'h1E;
  localparam logic [7:0] NR41 = 8'h20;
  localparam logic [7:0] NR44 = 8'h23;
  localparam logic [7:0] NR52 = 8'h26;

  // Bit s set means the unit ticks when the sequencer leaves step s.
  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [2:0] ENV_STEP    = 3'd7;

  localparam logic [1:0] CH1 = 2'd0;
  localparam logic [1:0] CH2 = 2'd1;
  localparam logic [1:0] CH3 = 2'd2;
  localparam logic [1:0] CH4 = 2'd3;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } trig_sel_t;

  function automatic trig_sel_t decode_trig(input logic [7:0] addr);
    trig_sel_t t;
    t.hit = 1'b1;
    t.idx = CH1;
    case (addr)
      NR14:    t.idx = CH1;
      NR24:    t.idx = CH2;
      NR34:    t.idx = CH3;
      NR44:    t.idx = CH4;
      default: t.hit = 1'b0;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sound_step_ctr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sound_step_ctr : 8-step frame sequencer; emits length/sweep/envelope ticks
//                  decoded from the step being left.
// Rev 1.0
// ----------------------------------------------------------------------------
module sound_step_ctr
  import sound_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       evt_i,
  output logic [2:0] step_o,
  output logic       len_tick_o,
  output logic       sweep_tick_o,
  output logic       env_tick_o
);

  logic [2:0] step_q, step_d;
  logic       len_q, len_d;
  logic       sweep_q, sweep_d;
  logic       env_q, env_d;

  always_comb begin
    step_d  = step_q;
    len_d   = 1'b0;
    sweep_d = 1'b0;
    env_d   = 1'b0;
    if (!en_i) begin
      step_d = 3'd0;
    end else if (evt_i) begin
      step_d  = step_q + 3'd1;
      len_d   = LEN_STEPS[step_q];
      sweep_d = SWEEP_STEPS[step_q];
      env_d   = (step_q == ENV_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q  <= 3'd0;
      len_q   <= 1'b0;
      sweep_q <= 1'b0;
      env_q   <= 1'b0;
    end else begin
      step_q  <= step_d;
      len_q   <= len_d;
      sweep_q <= sweep_d;
      env_q   <= env_d;
    end
  end

  assign step_o       = step_q;
  assign len_tick_o   = len_q;
  assign sweep_tick_o = sweep_q;
  assign env_tick_o   = env_q;

endmodule
`default_nettype wire

// File: rtl/sound_ctrl_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sound_ctrl_seq : APU frame sequencer plus length/trigger register decode.
//                  SOUND_DIV_EDGE_EN: div_in is the raw DIV bit (falling edge).
// Rev 1.0
// ----------------------------------------------------------------------------
module sound_ctrl_seq
  import sound_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       div_in,
  input  logic       apu_en,
  input  logic       reg_wr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_din,
  output logic       len_tick,
  output logic       env_tick,
  output logic       sweep_tick,
  output logic [2:0] step,
  output logic [3:0] ch_start,
  output logic [3:0] ch_single,
  output logic [5:0] ch1_len,
  output logic [5:0] ch2_len,
  output logic [5:0] ch4_len,
  output logic [7:0] ch3_len
);

  logic div_evt;

`ifdef SOUND_DIV_EDGE_EN
  logic div_hist_q;

  always_ff @(posedge clk) begin
    if (rst) div_hist_q <= 1'b0;
    else     div_hist_q <= div_in;
  end

  assign div_evt = div_hist_q & ~div_in;
`else
  assign div_evt = div_in;
`endif

  sound_step_ctr u_step_ctr (
    .clk          (clk),
    .rst          (rst),
    .en_i         (apu_en),
    .evt_i        (div_evt),
    .step_o       (step),
    .len_tick_o   (len_tick),
    .sweep_tick_o (sweep_tick),
    .env_tick_o   (env_tick)
  );

  trig_sel_t  trig;
  logic [3:0] start_q, start_d;
  logic [3:0] single_q, single_d;
  logic [5:0] len1_q, len1_d;
  logic [5:0] len2_q, len2_d;
  logic [7:0] len3_q, len3_d;
  logic [5:0] len4_q, len4_d;

  assign trig = decode_trig(reg_addr);

  always_comb begin
    start_d  = 4'd0;
    single_d = single_q;
    len1_d   = len1_q;
    len2_d   = len2_q;
    len3_d   = len3_q;
    len4_d   = len4_q;
    if (!apu_en) begin
      single_d = 4'd0;
      len1_d   = 6'd0;
      len2_d   = 6'd0;
      len3_d   = 8'd0;
      len4_d   = 6'd0;
    end else if (reg_wr) begin
      case (reg_addr)
        NR11:    len1_d = reg_din[5:0];
        NR21:    len2_d = reg_din[5:0];
        NR31:    len3_d = reg_din;
        NR41:    len4_d = reg_din[5:0];
        default: ;
      endcase
      // Start and length-enable share one register edge so consumers see both.
      if (trig.hit) begin
        single_d[trig.idx] = reg_din[6];
        start_d[trig.idx]  = reg_din[7];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= 4'd0;
      single_q <= 4'd0;
      len1_q   <= 6'd0;
      len2_q   <= 6'd0;
      len3_q   <= 8'd0;
      len4_q   <= 6'd0;
    end else begin
      start_q  <= start_d;
      single_q <= single_d;
      len1_q   <= len1_d;
      len2_q   <= len2_d;
      len3_q   <= len3_d;
      len4_q   <= len4_d;
    end
  end

  assign ch_start  = start_q;
  assign ch_single = single_q;
  assign ch1_len   = len1_q;
  assign ch2_len   = len2_q;
  assign ch3_len   = len3_q;
  assign ch4_len   = len4_q;

endmodule
`default_nettype wire

// File: tb/tb_sound_ctrl_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sound_ctrl_seq : directed scenarios plus randomized traffic against a
//                     behavioural model of the frame sequencer and registers.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sound_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst, div_in, apu_en, reg_wr;
  logic [7:0] reg_addr, reg_din;
  logic       len_tick, env_tick, sweep_tick;
  logic [2:0] step;
  logic [3:0] ch_start, ch_single;
  logic [5:0] ch1_len, ch2_len, ch4_len;
  logic [7:0] ch3_len;

  int checks = 0;
  int errors = 0;
  int n_len, n_sweep, n_env, n_start;

  sound_ctrl_seq dut (
    .clk        (clk),
    .rst        (rst),
    .div_in     (div_in),
    .apu_en     (apu_en),
    .reg_wr     (reg_wr),
    .reg_addr   (reg_addr),
    .reg_din    (reg_din),
    .len_tick   (len_tick),
    .env_tick   (env_tick),
    .sweep_tick (sweep_tick),
    .step       (step),
    .ch_start   (ch_start),
    .ch_single  (ch_single),
    .ch1_len    (ch1_len),
    .ch2_len    (ch2_len),
    .ch4_len    (ch4_len),
    .ch3_len    (ch3_len)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    n_len   += int'(len_tick);
    n_sweep += int'(sweep_tick);
    n_env   += int'(env_tick);
    n_start += $countones(ch_start);
  endtask

  task automatic clear_counts();
    n_len = 0; n_sweep = 0; n_env = 0; n_start = 0;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_din = d;
    cyc();
    reg_wr = 1'b0;
  endtask

  // One 512 Hz event in either div_in interpretation; step advances once.
  task automatic do_event();
    div_in = 1'b1;
    cyc();
    div_in = 1'b0;
    cyc();
  endtask

  task automatic apply_reset();
    rst = 1'b1; div_in = 1'b0; reg_wr = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    clear_counts();
  endtask

  task automatic test_reset();
    rst = 1'b1; apu_en = 1'b1; div_in = 1'b1;
    reg_wr = 1'b1; reg_addr = 8'h14; reg_din = 8'hC0;
    cyc(); cyc();
    checks++;
    if ({step, len_tick, sweep_tick, env_tick, ch_start, ch_single,
         ch1_len, ch2_len, ch3_len, ch4_len} !== 40'd0) begin
      errors++;
      $display("FAIL reset_state: got step=%0d ticks=%b%b%b start=%b single=%b lens=%h/%h/%h/%h, expected all 0",
               step, len_tick, sweep_tick, env_tick, ch_start, ch_single, ch1_len, ch2_len, ch3_len, ch4_len);
    end
    rst = 1'b0; reg_wr = 1'b0; div_in = 1'b0;
    clear_counts();
    cyc(); cyc();
    checks++;
    if (step !== 3'd0 || n_len + n_sweep + n_env + n_start != 0) begin
      errors++;
      $display("FAIL reset_release: got step=%0d pulses=%0d, expected step=0 pulses=0",
               step, n_len + n_sweep + n_env + n_start);
    end
  endtask

  task automatic test_sequence();
    apply_reset();
    apu_en = 1'b1;
    cyc();
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      do_event();
      checks++;
      if (step !== 3'((i + 1) % 8)) begin
        errors++;
        $display("FAIL seq_step[%0d]: got %0d expected %0d", i, step, (i + 1) % 8);
      end
    end
    checks++;
    if (n_len != 4 || n_sweep != 2 || n_env != 1) begin
      errors++;
      $display("FAIL seq_counts: got len=%0d sweep=%0d env=%0d expected 4/2/1", n_len, n_sweep, n_env);
    end
  endtask

  task automatic test_trigger();
    write_reg(8'h14, 8'hC0);
    checks++;
    if (ch_start !== 4'b0001 || ch_single[0] !== 1'b1) begin
      errors++;
      $display("FAIL trig_ch1: got start=%b single0=%b expected 0001/1", ch_start, ch_single[0]);
    end
    cyc();
    checks++;
    if (ch_start !== 4'b0000 || ch_single[0] !== 1'b1) begin
      errors++;
      $display("FAIL trig_ch1_end: got start=%b single0=%b expected 0000/1", ch_start, ch_single[0]);
    end
  endtask

  task automatic test_len_trigger();
    clear_counts();
    write_reg(8'h1B, 8'hFF);
    checks++;
    if (ch3_len !== 8'hFF) begin
      errors++;
      $display("FAIL ch3_len: got %h expected ff", ch3_len);
    end
    write_reg(8'h1E, 8'h80);
    checks++;
    if (ch_start !== 4'b0100 || ch_single[2] !== 1'b0) begin
      errors++;
      $display("FAIL trig_ch3: got start=%b single2=%b expected 0100/0", ch_start, ch_single[2]);
    end
    cyc(); cyc();
    checks++;
    if (n_start != 1) begin
      errors++;
      $display("FAIL trig_ch3_count: got %0d start pulses expected 1", n_start);
    end
  endtask

  task automatic test_apu_off();
    apply_reset();
    apu_en = 1'b1;
    cyc();
    write_reg(8'h11, 8'h15);
    write_reg(8'h19, 8'h40);
    for (int i = 0; i < 5; i++) do_event();
    checks++;
    if (step !== 3'd5 || ch1_len !== 6'h15 || ch_single !== 4'b0010) begin
      errors++;
      $display("FAIL off_pre: got step=%0d ch1_len=%h single=%b expected 5/15/0010", step, ch1_len, ch_single);
    end
    apu_en = 1'b0;
    cyc();
    checks++;
    if (step !== 3'd0 || ch1_len !== 6'd0 || ch_single !== 4'd0) begin
      errors++;
      $display("FAIL off_clear: got step=%0d ch1_len=%h single=%b expected 0/00/0000", step, ch1_len, ch_single);
    end
    clear_counts();
    write_reg(8'h11, 8'h3F);
    write_reg(8'h14, 8'hC0);
    do_event(); do_event();
    checks++;
    if (step !== 3'd0 || ch1_len !== 6'd0 || n_len + n_sweep + n_env + n_start != 0) begin
      errors++;
      $display("FAIL off_hold: got step=%0d ch1_len=%h pulses=%0d expected 0/00/0",
               step, ch1_len, n_len + n_sweep + n_env + n_start);
    end
    apu_en = 1'b1;
    cyc();
    clear_counts();
    do_event();
    checks++;
    if (n_len != 1 || step !== 3'd1) begin
      errors++;
      $display("FAIL reenable: got len=%0d step=%0d expected 1/1", n_len, step);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    apu_en = 1'b1;
    cyc();
`ifdef SOUND_DIV_EDGE_EN
    div_in = 1'b1;
    cyc();
    div_in = 1'b0;
`else
    div_in = 1'b1;
`endif
    reg_wr = 1'b1; reg_addr = 8'h23; reg_din = 8'h80;
    cyc();
    reg_wr = 1'b0; div_in = 1'b0;
    checks++;
    if (ch_start !== 4'b1000 || len_tick !== 1'b1 || step !== 3'd1) begin
      errors++;
      $display("FAIL trig_and_tick: got start=%b len=%b step=%0d expected 1000/1/1", ch_start, len_tick, step);
    end
    cyc();
    do_event();
`ifdef SOUND_DIV_EDGE_EN
    div_in = 1'b1;
    cyc();
    div_in = 1'b0;
`else
    div_in = 1'b1;
`endif
    reg_wr = 1'b1; reg_addr = 8'h20; reg_din = 8'hEA;
    cyc();
    reg_wr = 1'b0; div_in = 1'b0;
    checks++;
    if (ch4_len !== 6'h2A || len_tick !== 1'b1 || sweep_tick !== 1'b1 || step !== 3'd3) begin
      errors++;
      $display("FAIL len_and_tick: got ch4_len=%h len=%b sweep=%b step=%0d expected 2a/1/1/3",
               ch4_len, len_tick, sweep_tick, step);
    end
    cyc();
  endtask

  task automatic test_div_mode();
    apply_reset();
    apu_en = 1'b1;
    cyc();
    clear_counts();
`ifdef SOUND_DIV_EDGE_EN
    div_in = 1'b1;
    repeat (10) cyc();
    checks++;
    if (step !== 3'd0) begin
      errors++;
      $display("FAIL edge_high: got step=%0d expected 0", step);
    end
    div_in = 1'b0;
    cyc();
    checks++;
    if (step !== 3'd1 || len_tick !== 1'b1) begin
      errors++;
      $display("FAIL edge_fall: got step=%0d len=%b expected 1/1", step, len_tick);
    end
    cyc(); cyc();
    checks++;
    if (step !== 3'd1 || n_len != 1) begin
      errors++;
      $display("FAIL edge_once: got step=%0d len=%0d expected 1/1", step, n_len);
    end
    do_event();
    div_in = 1'b1;
    repeat (3) cyc();
    div_in = 1'b0;
`else
    div_in = 1'b1;
    repeat (3) cyc();
    div_in = 1'b0;
    checks++;
    if (step !== 3'd3 || n_len != 2) begin
      errors++;
      $display("FAIL level_k: got step=%0d len=%0d expected 3/2", step, n_len);
    end
    do_event();
    checks++;
    if (step !== 3'd4) begin
      errors++;
      $display("FAIL level_after: got step=%0d expected 4", step);
    end
    div_in = 1'b1;
`endif
    rst = 1'b1;
    reg_wr = 1'b1; reg_addr = 8'h14; reg_din = 8'h80;
    cyc();
    rst = 1'b0; reg_wr = 1'b0; div_in = 1'b0;
    checks++;
    if (step !== 3'd0 || len_tick !== 1'b0 || sweep_tick !== 1'b0 || ch_start !== 4'd0) begin
      errors++;
      $display("FAIL rst_vs_tick: got step=%0d len=%b sweep=%b start=%b expected 0/0/0/0000",
               step, len_tick, sweep_tick, ch_start);
    end
    cyc();
  endtask

  task automatic test_random();
    logic [7:0]  addrs [12] = '{8'h11, 8'h14, 8'h16, 8'h19, 8'h1B, 8'h1E,
                               8'h20, 8'h23, 8'h26, 8'h12, 8'h00, 8'hFF};
    int          m_step;
    logic [3:0]  m_single, e_start;
    logic [5:0]  m_l1, m_l2, m_l4;
    logic [7:0]  m_l3;
    bit          m_prev, evt, e_len, e_sweep, e_env;
    logic [39:0] exp_v, act_v;
    int          ch;

    apu_en = 1'b0;
    apply_reset();
    m_step = 0; m_single = 4'd0; m_l1 = 6'd0; m_l2 = 6'd0; m_l3 = 8'd0; m_l4 = 6'd0;
    m_prev = 1'b0;

    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      apu_en   = ($urandom_range(0, 15) != 0);
      div_in   = ($urandom_range(0, 2) == 0);
      reg_wr   = ($urandom_range(0, 2) == 0);
      reg_addr = addrs[$urandom_range(0, 11)];
      reg_din  = 8'($urandom);

      e_len = 0; e_sweep = 0; e_env = 0; e_start = 4'd0;
      if (rst) begin
        m_step = 0; m_single = 4'd0; m_l1 = 6'd0; m_l2 = 6'd0; m_l3 = 8'd0; m_l4 = 6'd0;
        m_prev = 1'b0;
      end else begin
`ifdef SOUND_DIV_EDGE_EN
        evt = m_prev && !div_in;
`else
        evt = div_in;
`endif
        m_prev = div_in;
        if (!apu_en) begin
          m_step = 0; m_single = 4'd0; m_l1 = 6'd0; m_l2 = 6'd0; m_l3 = 8'd0; m_l4 = 6'd0;
        end else begin
          if (evt) begin
            e_len   = (m_step % 2 == 0);
            e_sweep = (m_step == 2 || m_step == 6);
            e_env   = (m_step == 7);
            m_step  = (m_step + 1) % 8;
          end
          if (reg_wr) begin
            ch = -1;
            case (reg_addr)
              8'h11: m_l1 = reg_din[5:0];
              8'h16: m_l2 = reg_din[5:0];
              8'h1B: m_l3 = reg_din;
              8'h20: m_l4 = reg_din[5:0];
              8'h14: ch = 0;
              8'h19: ch = 1;
              8'h1E: ch = 2;
              8'h23: ch = 3;
              default: ;
            endcase
            if (ch >= 0) begin
              m_single[ch] = reg_din[6];
              e_start[ch]  = reg_din[7];
            end
          end
        end
      end

      cyc();
      exp_v = {3'(m_step), e_len, e_sweep, e_env, e_start, m_single, m_l1, m_l2, m_l3, m_l4};
      act_v = {step, len_tick, sweep_tick, env_tick, ch_start, ch_single, ch1_len, ch2_len, ch3_len, ch4_len};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", n, act_v, exp_v);
      end
    end
    rst = 1'b0; reg_wr = 1'b0; div_in = 1'b0;
  endtask

  initial begin
    rst = 1'b0; div_in = 1'b0; apu_en = 1'b0; reg_wr = 1'b0;
    reg_addr = 8'h00; reg_din = 8'h00;
    clear_counts();
    test_reset();
    test_sequence();
    test_trigger();
    test_len_trigger();
    test_apu_off();
    test_back_to_back();
    test_div_mode();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
